// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcode constants, FSM state
// encoding and the cycle-counter sizing helper.
package instr_sequencer_pkg;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_CLR   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_LOADI = 4'd2,
        OP_ALU   = 4'd3,
        OP_REP   = 4'd4,
        OP_NOP   = 4'd5
    } opcode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    // Width that holds (2^arg_w)*clr_cycles without wrapping.
    function automatic int unsigned cyc_cnt_w(input int unsigned arg_w, input int unsigned clr_cycles);
        return $clog2((2 ** arg_w) * clr_cycles + 1);
    endfunction

endpackage

// File: rtl/instr_sequencer_op_decode.sv
// Combinational opcode/argument decode: strobe pattern, base length and
// illegal flag for one instruction.
module op_decode
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned ARG_W      = 4,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned CNT_W      = 6
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [ARG_W-1:0]    i_arg,
    output logic                o_clr,
    output logic [NUM_SRC-1:0]  o_en_reg,
    output logic                o_en_out,
    output logic                o_drv_load_sel,
    output logic                o_load_sel,
    output logic                o_drv_alu_sel,
    output logic [SEL_W-1:0]    o_alu_sel,
    output logic [CNT_W-1:0]    o_base_len,
    output logic                o_rep,
    output logic                o_illegal
);

    opcode_e w_op;
    logic    w_arg_in_range;

    assign w_op           = opcode_e'(i_opcode);
    assign w_arg_in_range = 32'(i_arg) < NUM_SRC;
    assign o_alu_sel      = i_arg[SEL_W-1:0];

    always_comb begin
        o_clr          = 1'b0;
        o_en_reg       = '0;
        o_en_out       = 1'b0;
        o_drv_load_sel = 1'b0;
        o_load_sel     = 1'b0;
        o_drv_alu_sel  = 1'b0;
        o_base_len     = CNT_W'(1);
        o_rep          = 1'b0;
        o_illegal      = 1'b0;
        case (w_op)
            OP_CLR: begin
                o_clr      = 1'b1;
                o_en_reg   = '1;
                o_en_out   = 1'b1;
                o_base_len = CNT_W'(CLR_CYCLES);
            end
            OP_LOAD, OP_LOADI: begin
                // Register index beyond the operand file is an illegal instruction.
                if (w_arg_in_range) begin
                    o_en_reg       = NUM_SRC'(1) << i_arg;
                    o_drv_load_sel = 1'b1;
                    o_load_sel     = (w_op == OP_LOADI);
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_ALU: begin
                o_en_out      = 1'b1;
                o_drv_alu_sel = 1'b1;
            end
            OP_REP:  o_rep = 1'b1;
            OP_NOP:  ;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction at a time, expands it (with an
// optional repeat count) into registered datapath strobes.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned ARG_W      = 4,
    parameter int unsigned CLR_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    input  logic [OPCODE_W+ARG_W-1:0] instr_data,
    output logic                      instr_ready,
    output logic                      clr,
    output logic [NUM_SRC-1:0]        en_reg,
    output logic                      load_sel,
    output logic                      en_out,
    output logic [SEL_W-1:0]          alu_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal_op
);

    localparam int unsigned CNT_W = cyc_cnt_w(ARG_W, CLR_CYCLES);

    state_e               r_state,       w_state_nxt;
    logic                 r_rep_pending, w_rep_pending_nxt;
    logic [ARG_W-1:0]     r_rep_cnt,     w_rep_cnt_nxt;
    logic [CNT_W-1:0]     r_cyc_cnt,     w_cyc_cnt_nxt;
    logic                 r_pat_clr,     w_pat_clr_nxt;
    logic [NUM_SRC-1:0]   r_pat_en_reg,  w_pat_en_reg_nxt;
    logic                 r_pat_en_out,  w_pat_en_out_nxt;
    logic                 r_ready,       w_ready_nxt;
    logic                 r_clr,         w_clr_nxt;
    logic [NUM_SRC-1:0]   r_en_reg,      w_en_reg_nxt;
    logic                 r_en_out,      w_en_out_nxt;
    logic                 r_load_sel,    w_load_sel_nxt;
    logic [SEL_W-1:0]     r_alu_sel,     w_alu_sel_nxt;
    logic                 r_busy,        w_busy_nxt;
    logic                 r_done,        w_done_nxt;
    logic                 r_illegal,     w_illegal_nxt;

    logic [OPCODE_W-1:0]  w_opcode;
    logic [ARG_W-1:0]     w_arg;
    logic                 w_accept;
    logic                 w_dec_clr, w_dec_en_out, w_dec_drv_load_sel, w_dec_load_sel;
    logic                 w_dec_drv_alu_sel, w_dec_rep, w_dec_illegal;
    logic [NUM_SRC-1:0]   w_dec_en_reg;
    logic [SEL_W-1:0]     w_dec_alu_sel;
    logic [CNT_W-1:0]     w_dec_base_len;
    logic [CNT_W-1:0]     w_factor;
    logic [CNT_W-1:0]     w_len;

    assign w_opcode = instr_data[ARG_W +: OPCODE_W];
    assign w_arg    = instr_data[ARG_W-1:0];
    assign w_accept = instr_valid && r_ready;
    assign w_factor = r_rep_pending ? (CNT_W'(r_rep_cnt) + CNT_W'(1)) : CNT_W'(1);
    assign w_len    = w_factor * w_dec_base_len;

    op_decode #(
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .ARG_W      (ARG_W),
        .CLR_CYCLES (CLR_CYCLES),
        .CNT_W      (CNT_W)
    ) u_op_decode (
        .i_opcode       (w_opcode),
        .i_arg          (w_arg),
        .o_clr          (w_dec_clr),
        .o_en_reg       (w_dec_en_reg),
        .o_en_out       (w_dec_en_out),
        .o_drv_load_sel (w_dec_drv_load_sel),
        .o_load_sel     (w_dec_load_sel),
        .o_drv_alu_sel  (w_dec_drv_alu_sel),
        .o_alu_sel      (w_dec_alu_sel),
        .o_base_len     (w_dec_base_len),
        .o_rep          (w_dec_rep),
        .o_illegal      (w_dec_illegal)
    );

    // Next-state and next-output logic; r_cyc_cnt counts cycles remaining after the current one.
    always_comb begin
        w_state_nxt       = r_state;
        w_rep_pending_nxt = r_rep_pending;
        w_rep_cnt_nxt     = r_rep_cnt;
        w_cyc_cnt_nxt     = r_cyc_cnt;
        w_pat_clr_nxt     = r_pat_clr;
        w_pat_en_reg_nxt  = r_pat_en_reg;
        w_pat_en_out_nxt  = r_pat_en_out;
        w_ready_nxt       = 1'b1;
        w_clr_nxt         = 1'b0;
        w_en_reg_nxt      = '0;
        w_en_out_nxt      = 1'b0;
        w_load_sel_nxt    = r_load_sel;
        w_alu_sel_nxt     = r_alu_sel;
        w_busy_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        w_illegal_nxt     = 1'b0;
        if (w_accept) begin
            if (w_dec_illegal) begin
                w_state_nxt       = S_EXEC;
                w_rep_pending_nxt = 1'b0;
                w_cyc_cnt_nxt     = '0;
                w_pat_clr_nxt     = 1'b0;
                w_pat_en_reg_nxt  = '0;
                w_pat_en_out_nxt  = 1'b0;
                w_illegal_nxt     = 1'b1;
            end else if (w_dec_rep) begin
                w_state_nxt       = S_IDLE;
                w_rep_pending_nxt = 1'b1;
                w_rep_cnt_nxt     = w_arg;
            end else begin
                w_state_nxt       = S_EXEC;
                w_rep_pending_nxt = 1'b0;
                w_cyc_cnt_nxt     = w_len - CNT_W'(1);
                w_pat_clr_nxt     = w_dec_clr;
                w_pat_en_reg_nxt  = w_dec_en_reg;
                w_pat_en_out_nxt  = w_dec_en_out;
                w_clr_nxt         = w_dec_clr;
                w_en_reg_nxt      = w_dec_en_reg;
                w_en_out_nxt      = w_dec_en_out;
                if (w_dec_drv_load_sel) w_load_sel_nxt = w_dec_load_sel;
                if (w_dec_drv_alu_sel)  w_alu_sel_nxt  = w_dec_alu_sel;
                w_busy_nxt        = (w_len != CNT_W'(1));
                w_done_nxt        = !w_busy_nxt;
                w_ready_nxt       = w_done_nxt;
            end
        end else if (r_state == S_EXEC) begin
            if (r_cyc_cnt == '0) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_cyc_cnt_nxt = r_cyc_cnt - CNT_W'(1);
                w_clr_nxt     = r_pat_clr;
                w_en_reg_nxt  = r_pat_en_reg;
                w_en_out_nxt  = r_pat_en_out;
                w_busy_nxt    = (w_cyc_cnt_nxt != '0);
                w_done_nxt    = !w_busy_nxt;
                w_ready_nxt   = w_done_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rep_pending <= 1'b0;
            r_rep_cnt     <= '0;
            r_cyc_cnt     <= '0;
            r_pat_clr     <= 1'b0;
            r_pat_en_reg  <= '0;
            r_pat_en_out  <= 1'b0;
            r_ready       <= 1'b0;
            r_clr         <= 1'b0;
            r_en_reg      <= '0;
            r_en_out      <= 1'b0;
            r_load_sel    <= 1'b0;
            r_alu_sel     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rep_pending <= w_rep_pending_nxt;
            r_rep_cnt     <= w_rep_cnt_nxt;
            r_cyc_cnt     <= w_cyc_cnt_nxt;
            r_pat_clr     <= w_pat_clr_nxt;
            r_pat_en_reg  <= w_pat_en_reg_nxt;
            r_pat_en_out  <= w_pat_en_out_nxt;
            r_ready       <= w_ready_nxt;
            r_clr         <= w_clr_nxt;
            r_en_reg      <= w_en_reg_nxt;
            r_en_out      <= w_en_out_nxt;
            r_load_sel    <= w_load_sel_nxt;
            r_alu_sel     <= w_alu_sel_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_illegal     <= w_illegal_nxt;
        end
    end

    assign instr_ready = r_ready;
    assign clr         = r_clr;
    assign en_reg      = r_en_reg;
    assign en_out      = r_en_out;
    assign load_sel    = r_load_sel;
    assign alu_sel     = r_alu_sel;
    assign busy        = r_busy;
    assign done        = r_done;
    assign illegal_op  = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer (default parameters): each issued
// instruction pushes its expected per-cycle output records.
module tb_instr_sequencer;

    typedef struct packed {
        logic       clr;
        logic [1:0] en_reg;
        logic       en_out;
        logic       load_sel;
        logic [2:0] alu_sel;
        logic       busy;
        logic       done;
        logic       illegal;
        logic       ready;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr_data;
    logic       instr_ready, clr, load_sel, en_out, busy, done, illegal_op;
    logic [1:0] en_reg;
    logic [2:0] alu_sel;

    rec_t obs_q[$];
    rec_t exp_q[$];
    bit   cap_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       m_rep;
    logic [3:0] m_cnt;
    logic       m_load_sel;
    logic [2:0] m_alu_sel;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_ready (instr_ready),
        .clr         (clr),
        .en_reg      (en_reg),
        .load_sel    (load_sel),
        .en_out      (en_out),
        .alu_sel     (alu_sel),
        .busy        (busy),
        .done        (done),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic rec_t cur_rec();
        rec_t r;
        r.clr = clr; r.en_reg = en_reg; r.en_out = en_out; r.load_sel = load_sel;
        r.alu_sel = alu_sel; r.busy = busy; r.done = done; r.illegal = illegal_op;
        r.ready = instr_ready;
        return r;
    endfunction

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.load_sel = m_load_sel;
        r.alu_sel  = m_alu_sel;
        r.ready    = 1'b1;
        return r;
    endfunction

    always @(negedge clk) if (cap_en) obs_q.push_back(cur_rec());

    // Expands one instruction into expected cycles, then drives it until accepted.
    task automatic send(input logic [3:0] op, input logic [3:0] arg, input bit push);
        rec_t r;
        int   len;
        bit   rdy;
        bit   ok;
        if (push) begin
            if (op == 4'd4) begin
                m_rep = 1'b1; m_cnt = arg;
                exp_q.push_back(idle_rec());
            end else if (op > 4'd5 || ((op == 4'd1 || op == 4'd2) && arg >= 4'd2)) begin
                m_rep = 1'b0;
                r = idle_rec(); r.illegal = 1'b1;
                exp_q.push_back(r);
            end else begin
                len = (op == 4'd0) ? 2 : 1;
                if (m_rep) len = len * (int'(m_cnt) + 1);
                m_rep = 1'b0;
                if (op == 4'd1) m_load_sel = 1'b0;
                if (op == 4'd2) m_load_sel = 1'b1;
                if (op == 4'd3) m_alu_sel = arg[2:0];
                for (int i = 0; i < len; i++) begin
                    r = idle_rec();
                    r.clr    = (op == 4'd0);
                    r.en_reg = (op == 4'd0) ? 2'b11 : ((op == 4'd1 || op == 4'd2) ? (2'b01 << arg) : 2'b00);
                    r.en_out = (op == 4'd0 || op == 4'd3);
                    r.busy   = (i < len - 1);
                    r.done   = (i == len - 1);
                    r.ready  = (i == len - 1);
                    exp_q.push_back(r);
                end
            end
        end
        instr_valid = 1'b1;
        instr_data  = {op, arg};
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            rdy = instr_ready;
            @(posedge clk); #1;
            ok = rdy;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout op=%0d got ready=0 required ready=1", op);
        end
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(idle_rec());
            @(posedge clk); #1;
        end
    endtask

    task automatic start_capture();
        @(posedge clk); #1;
        obs_q.delete(); exp_q.delete();
        cap_en = 1'b1;
        exp_q.push_back(idle_rec());
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_valid = 1'b1; instr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({clr, en_reg, en_out, busy, done, illegal_op} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes got=%b required=0000000", {clr, en_reg, en_out, busy, done, illegal_op});
        end
        checks++; if ({load_sel, alu_sel} !== 4'b0) begin
            errors++; $display("FAIL reset_sels got=%b required=0000", {load_sel, alu_sel});
        end
        checks++; if (instr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low got=%b required=0", instr_ready);
        end
        reset = 1'b0; instr_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || clr !== 1'b0) begin
            errors++; $display("FAIL reset_release got ready=%b clr=%b required ready=1 clr=0", instr_ready, clr);
        end
        m_rep = 1'b0; m_cnt = 4'd0; m_load_sel = 1'b0; m_alu_sel = 3'd0;
    endtask

    task automatic test_clr();
        rec_t o, e;
        int   n = 0;
        start_capture();
        send(4'd0, 4'd0, 1'b1);
        idle(3);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        cap_en = 1'b0;
        checks++; if (obs_q.size() < exp_q.size()) begin
            errors++; $display("FAIL clr_timeout got=%0d required=%0d records", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL clr_cycle%0d got=%b required=%b", n, o, e); end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        int   n = 0;
        start_capture();
        send(4'd1, 4'd1, 1'b1);
        send(4'd2, 4'd0, 1'b1);
        send(4'd3, 4'd5, 1'b1);
        idle(3);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        cap_en = 1'b0;
        checks++; if (obs_q.size() < exp_q.size()) begin
            errors++; $display("FAIL b2b_timeout got=%0d required=%0d records", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_cycle%0d got=%b required=%b", n, o, e); end
            n++;
        end
    endtask

    task automatic test_repeat();
        rec_t o, e;
        int   n = 0;
        start_capture();
        send(4'd4, 4'd3, 1'b1);
        send(4'd3, 4'd2, 1'b1);
        send(4'd5, 4'd0, 1'b1);
        send(4'd1, 4'd0, 1'b1);
        idle(2);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        cap_en = 1'b0;
        checks++; if (obs_q.size() < exp_q.size()) begin
            errors++; $display("FAIL rep_timeout got=%0d required=%0d records", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL rep_cycle%0d got=%b required=%b", n, o, e); end
            n++;
        end
    endtask

    task automatic test_rep_clr();
        rec_t o, e;
        int   n = 0;
        start_capture();
        send(4'd4, 4'd1, 1'b1);
        send(4'd0, 4'd0, 1'b1);
        send(4'd4, 4'd7, 1'b1);
        send(4'd4, 4'd1, 1'b1);
        send(4'd0, 4'd0, 1'b1);
        idle(2);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        cap_en = 1'b0;
        checks++; if (obs_q.size() < exp_q.size()) begin
            errors++; $display("FAIL repclr_timeout got=%0d required=%0d records", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL repclr_cycle%0d got=%b required=%b", n, o, e); end
            n++;
        end
    endtask

    task automatic test_illegal();
        rec_t o, e;
        int   n = 0;
        start_capture();
        send(4'd1, 4'd2, 1'b1);
        send(4'd2, 4'd3, 1'b1);
        send(4'd9, 4'd0, 1'b1);
        idle(1);
        send(4'd4, 4'd2, 1'b1);
        send(4'd9, 4'd0, 1'b1);
        send(4'd3, 4'd0, 1'b1);
        send(4'd15, 4'd15, 1'b1);
        idle(2);
        for (int i = 0; i < 200 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
        cap_en = 1'b0;
        checks++; if (obs_q.size() < exp_q.size()) begin
            errors++; $display("FAIL illegal_timeout got=%0d required=%0d records", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL illegal_cycle%0d got=%b required=%b", n, o, e); end
            n++;
        end
    endtask

    task automatic test_reset_mid_clr();
        @(posedge clk); #1;
        send(4'd4, 4'd5, 1'b0);
        send(4'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (clr !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL midclr_cycle3 got clr=%b busy=%b done=%b required 1 1 0", clr, busy, done);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (cur_rec() !== rec_t'(0)) begin
            errors++; $display("FAIL midclr_abort got=%b required=%b", cur_rec(), rec_t'(0));
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1 || done !== 1'b0 || clr !== 1'b0) begin
            errors++; $display("FAIL midclr_release got ready=%b done=%b clr=%b required 1 0 0", instr_ready, done, clr);
        end
        // Repeat count must be gone: a fresh CLR lasts exactly two cycles.
        send(4'd0, 4'd0, 1'b0);
        checks++; if (clr !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL midclr_norep_c1 got clr=%b busy=%b required 1 1", clr, busy);
        end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midclr_norep_c2 got done=%b busy=%b required 1 0", done, busy);
        end
        @(posedge clk); #1;
        reset = 1'b1; instr_valid = 1'b1; instr_data = 8'h00;
        @(posedge clk); #1;
        checks++; if (clr !== 1'b0 || instr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_priority got clr=%b ready=%b required 0 0", clr, instr_ready);
        end
        reset = 1'b0; instr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr_data = 8'h00;
        m_rep = 1'b0; m_cnt = 4'd0; m_load_sel = 1'b0; m_alu_sel = 3'd0;
        test_reset();
        test_clr();
        test_back_to_back();
        test_repeat();
        test_rep_clr();
        test_illegal();
        test_reset_mid_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
